dict_fifo_mw: RTL and testbench

DICT_FIFO_MW -- requirements
Module: dict_fifo_mw

---
 rtl/dict_fifo_pkg.sv | 27 ++
 rtl/dict_lane_packer.sv | 24 ++
 rtl/dict_fifo_mw.sv | 147 ++++++++++++++
 tb/tb_dict_fifo_mw.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/dict_fifo_pkg.sv
// Shared helpers for the multi-lane dictionary FIFO: lane-offset type,
// pointer/count width helpers and the lane popcount.
package dict_fifo_pkg;

  localparam int MAX_LANES  = 4;
  localparam int LANE_OFF_W = 3;

  typedef logic [LANE_OFF_W-1:0] lane_off_t;

  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic lane_off_t popcount(input logic [MAX_LANES-1:0] v);
    lane_off_t c;
    c = '0;
    for (int i = 0; i < MAX_LANES; i++) begin
      c = c + lane_off_t'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/dict_lane_packer.sv
// Combinational lane packer: slot offset of each lane relative to the write
// pointer (enabled lanes below it) and the total number of enabled lanes.
module dict_lane_packer
  import dict_fifo_pkg::*;
#(
  parameter int LANES = 2
) (
  input  logic [LANES-1:0] wr_en,
  output lane_off_t        lane_off [LANES],
  output lane_off_t        total
);

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_off
      logic [MAX_LANES-1:0] below;
      assign below        = MAX_LANES'(wr_en & LANES'((1 << gi) - 1));
      assign lane_off[gi] = popcount(below);
    end
  endgenerate

  assign total = popcount(MAX_LANES'(wr_en));

endmodule

// File: rtl/dict_fifo_mw.sv
// Multi-lane write dictionary FIFO with overwrite-oldest behaviour and flush.
// Optional lookup engine enabled by defining DICT_FIFO_LOOKUP_EN.
module dict_fifo_mw
  import dict_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int LANES      = 2
) (
  input  logic                        i_clk,
  input  logic                        i_reset_n,
  input  logic [LANES-1:0]            i_wr_en,
  input  logic [LANES*DATA_WIDTH-1:0] i_wr_data,
  input  logic                        i_flush,
  output logic [DEPTH*DATA_WIDTH-1:0] o_dict,
  output logic [DEPTH-1:0]            o_valid,
  output logic [$clog2(DEPTH):0]      o_count,
  output logic                        o_full,
  output logic [$clog2(DEPTH)-1:0]    o_wr_ptr,
  input  logic                        i_lk_en,
  input  logic [DATA_WIDTH-1:0]       i_lk_data,
  output logic                        o_lk_valid,
  output logic                        o_lk_hit,
  output logic [DEPTH-1:0]            o_lk_mask
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = cnt_width(DEPTH);

  logic [DATA_WIDTH-1:0] dict_reg  [DEPTH];
  logic [DATA_WIDTH-1:0] dict_next [DEPTH];
  logic [DEPTH-1:0]      valid_reg, valid_next;
  logic [CNT_W-1:0]      count_reg, count_next;
  logic [PTR_W-1:0]      wr_ptr_reg, wr_ptr_next;
  logic                  full_reg, full_next;
  logic [CNT_W:0]        count_sum;
  logic [PTR_W-1:0]      slot;

  logic [DATA_WIDTH-1:0] lane_data [LANES];
  lane_off_t             lane_off  [LANES];
  lane_off_t             total;

  dict_lane_packer #(.LANES(LANES)) u_packer (
    .wr_en    (i_wr_en),
    .lane_off (lane_off),
    .total    (total)
  );

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign lane_data[gi] = i_wr_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end
    for (gi = 0; gi < DEPTH; gi++) begin : g_dict
      assign o_dict[gi*DATA_WIDTH +: DATA_WIDTH] = dict_reg[gi];
    end
  endgenerate

  // Valid entries always form a contiguous run ending at the write pointer,
  // so the newly valid slots are simply the write total, capped at DEPTH.
  always_comb begin
    dict_next   = dict_reg;
    valid_next  = valid_reg;
    count_next  = count_reg;
    wr_ptr_next = wr_ptr_reg;
    count_sum   = '0;
    slot        = '0;
    if (i_flush) begin
      valid_next  = '0;
      count_next  = '0;
      wr_ptr_next = '0;
    end else if (|i_wr_en) begin
      for (int k = 0; k < LANES; k++) begin
        if (i_wr_en[k]) begin
          slot             = wr_ptr_reg + PTR_W'(lane_off[k]);
          dict_next[slot]  = lane_data[k];
          valid_next[slot] = 1'b1;
        end
      end
      wr_ptr_next = wr_ptr_reg + PTR_W'(total);
      count_sum   = (CNT_W+1)'(count_reg) + (CNT_W+1)'(total);
      count_next  = (count_sum >= (CNT_W+1)'(DEPTH)) ? CNT_W'(DEPTH)
                                                      : count_sum[CNT_W-1:0];
    end
    full_next = (count_next == CNT_W'(DEPTH));
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      for (int e = 0; e < DEPTH; e++) begin
        dict_reg[e] <= '0;
      end
      valid_reg  <= '0;
      count_reg  <= '0;
      wr_ptr_reg <= '0;
      full_reg   <= 1'b0;
    end else begin
      dict_reg   <= dict_next;
      valid_reg  <= valid_next;
      count_reg  <= count_next;
      wr_ptr_reg <= wr_ptr_next;
      full_reg   <= full_next;
    end
  end

  assign o_valid  = valid_reg;
  assign o_count  = count_reg;
  assign o_full   = full_reg;
  assign o_wr_ptr = wr_ptr_reg;

`ifdef DICT_FIFO_LOOKUP_EN
  logic [DEPTH-1:0] lk_mask_next, lk_mask_reg;
  logic             lk_valid_reg, lk_hit_reg;

  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_cmp
      assign lk_mask_next[gi] = valid_reg[gi] && (dict_reg[gi] == i_lk_data);
    end
  endgenerate

  // Lookup sees the pre-edge dictionary; results hold while i_lk_en is low.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      lk_valid_reg <= 1'b0;
      lk_hit_reg   <= 1'b0;
      lk_mask_reg  <= '0;
    end else begin
      lk_valid_reg <= i_lk_en;
      if (i_lk_en) begin
        lk_mask_reg <= lk_mask_next;
        lk_hit_reg  <= |lk_mask_next;
      end
    end
  end

  assign o_lk_valid = lk_valid_reg;
  assign o_lk_hit   = lk_hit_reg;
  assign o_lk_mask  = lk_mask_reg;
`else
  logic lk_unused;
  assign lk_unused  = ^{i_lk_en, i_lk_data};
  assign o_lk_valid = 1'b0;
  assign o_lk_hit   = 1'b0;
  assign o_lk_mask  = '0;
`endif

endmodule

// File: tb/tb_dict_fifo_mw.sv
// Directed self-checking bench for dict_fifo_mw (32-bit, 16 entries, 2 lanes).
// Lookup checks adapt to whether DICT_FIFO_LOOKUP_EN is defined.
module tb_dict_fifo_mw;

  localparam int DW = 32;
  localparam int DP = 16;
  localparam int LN = 2;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [LN-1:0]    wr_en;
  logic [LN*DW-1:0] wr_data;
  logic             flush;
  logic [DP*DW-1:0] dict;
  logic [DP-1:0]    valid;
  logic [4:0]       count;
  logic             full;
  logic [3:0]       wr_ptr;
  logic             lk_en;
  logic [DW-1:0]    lk_data;
  logic             lk_valid;
  logic             lk_hit;
  logic [DP-1:0]    lk_mask;

  int tests = 0;
  int fails = 0;

  dict_fifo_mw #(.DATA_WIDTH(DW), .DEPTH(DP), .LANES(LN)) dut (
    .i_clk      (clk),
    .i_reset_n  (reset_n),
    .i_wr_en    (wr_en),
    .i_wr_data  (wr_data),
    .i_flush    (flush),
    .o_dict     (dict),
    .o_valid    (valid),
    .o_count    (count),
    .o_full     (full),
    .o_wr_ptr   (wr_ptr),
    .i_lk_en    (lk_en),
    .i_lk_data  (lk_data),
    .o_lk_valid (lk_valid),
    .o_lk_hit   (lk_hit),
    .o_lk_mask  (lk_mask)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("[TB] check %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [DW-1:0] slot(input int e);
    return dict[e*DW +: DW];
  endfunction

  task automatic wr(input logic [1:0] en, input logic [31:0] d0, input logic [31:0] d1);
    wr_en   = en;
    wr_data = {d1, d0};
    tick();
    wr_en   = 2'b00;
  endtask

  initial begin
    reset_n = 1'b0;
    wr_en   = 2'b11;
    wr_data = {32'hFFFF_0001, 32'hFFFF_0000};
    flush   = 1'b0;
    lk_en   = 1'b1;
    lk_data = 32'h0;
    tick();
    tick();
    wr_en = 2'b00;
    lk_en = 1'b0;
    check("rst_count", 64'(count), 64'd0);
    check("rst_full", 64'(full), 64'd0);
    check("rst_valid", 64'(valid), 64'h0);
    check("rst_ptr", 64'(wr_ptr), 64'd0);
    check("rst_dict_or", 64'(|dict), 64'd0);
    check("rst_lk_valid", 64'(lk_valid), 64'd0);
    check("rst_lk_mask", 64'(lk_mask), 64'h0);
    reset_n = 1'b1;

    wr(2'b01, 32'hDEADBEEF, 32'h0);
    check("w1_slot0", 64'(slot(0)), 64'hDEADBEEF);
    check("w1_count", 64'(count), 64'd1);
    check("w1_ptr", 64'(wr_ptr), 64'd1);
    check("w1_valid", 64'(valid), 64'h0001);

    wr(2'b11, 32'hCAFEBABE, 32'h12345678);
    check("w2_slot1", 64'(slot(1)), 64'hCAFEBABE);
    check("w2_slot2", 64'(slot(2)), 64'h12345678);
    check("w2_count", 64'(count), 64'd3);
    check("w2_ptr", 64'(wr_ptr), 64'd3);

    wr(2'b10, 32'h0, 32'hA5A5A5A5);
    check("w3_slot3", 64'(slot(3)), 64'hA5A5A5A5);
    check("w3_slot4", 64'(slot(4)), 64'h0);
    check("w3_ptr", 64'(wr_ptr), 64'd4);
    check("w3_count", 64'(count), 64'd4);

    lk_en   = 1'b1;
    lk_data = 32'h12345678;
    tick();
    check("idle_count", 64'(count), 64'd4);
    check("idle_ptr", 64'(wr_ptr), 64'd4);
`ifdef DICT_FIFO_LOOKUP_EN
    check("lk1_valid", 64'(lk_valid), 64'd1);
    check("lk1_hit", 64'(lk_hit), 64'd1);
    check("lk1_mask", 64'(lk_mask), 64'h0004);
`else
    check("lk1_valid_tied", 64'(lk_valid), 64'd0);
    check("lk1_hit_tied", 64'(lk_hit), 64'd0);
    check("lk1_mask_tied", 64'(lk_mask), 64'h0);
`endif
    lk_en   = 1'b0;
    lk_data = 32'h0;
    tick();
    check("lk_hold_valid", 64'(lk_valid), 64'd0);
`ifdef DICT_FIFO_LOOKUP_EN
    check("lk_hold_mask", 64'(lk_mask), 64'h0004);
`else
    check("lk_hold_mask_tied", 64'(lk_mask), 64'h0);
`endif

    for (int i = 0; i < 5; i++) wr(2'b11, 32'h100 + 2*i, 32'h101 + 2*i);
    check("f14_count", 64'(count), 64'd14);
    check("f14_full", 64'(full), 64'd0);
    wr(2'b11, 32'h10A, 32'h10B);
    check("f16_full", 64'(full), 64'd1);
    check("f16_count", 64'(count), 64'd16);
    check("f16_ptr", 64'(wr_ptr), 64'd0);
    check("f16_valid", 64'(valid), 64'hFFFF);
    check("f16_slot15", 64'(slot(15)), 64'h10B);

    wr(2'b11, 32'h11111111, 32'h22222222);
    check("ow_slot0", 64'(slot(0)), 64'h11111111);
    check("ow_slot1", 64'(slot(1)), 64'h22222222);
    check("ow_count", 64'(count), 64'd16);
    check("ow_ptr", 64'(wr_ptr), 64'd2);

    for (int i = 0; i < 6; i++) wr(2'b11, 32'h200 + 2*i, 32'h201 + 2*i);
    wr(2'b01, 32'h20C, 32'h0);
    check("odd_ptr15", 64'(wr_ptr), 64'd15);
    wr(2'b11, 32'hAAAA0000, 32'hBBBB0000);
    check("odd_slot15", 64'(slot(15)), 64'hAAAA0000);
    check("odd_slot0", 64'(slot(0)), 64'hBBBB0000);
    check("odd_ptr", 64'(wr_ptr), 64'd1);
    check("odd_count", 64'(count), 64'd16);

    lk_en   = 1'b1;
    lk_data = 32'h22222222;
    tick();
    lk_en = 1'b0;
`ifdef DICT_FIFO_LOOKUP_EN
    check("lk2_hit", 64'(lk_hit), 64'd1);
    check("lk2_mask", 64'(lk_mask), 64'h0002);
`endif

    flush   = 1'b1;
    wr(2'b11, 32'hCCCC0000, 32'hDDDD0000);
    flush   = 1'b0;
    check("fl_valid", 64'(valid), 64'h0);
    check("fl_count", 64'(count), 64'd0);
    check("fl_ptr", 64'(wr_ptr), 64'd0);
    check("fl_full", 64'(full), 64'd0);
    check("fl_slot1", 64'(slot(1)), 64'h22222222);
    check("fl_slot2", 64'(slot(2)), 64'h200);

    lk_en   = 1'b1;
    lk_data = 32'h22222222;
    tick();
    lk_en = 1'b0;
    check("lk3_hit", 64'(lk_hit), 64'd0);
    check("lk3_mask", 64'(lk_mask), 64'h0);
`ifdef DICT_FIFO_LOOKUP_EN
    check("lk3_valid", 64'(lk_valid), 64'd1);
`endif

    wr(2'b10, 32'h0, 32'h5555AAAA);
    check("pf_slot0", 64'(slot(0)), 64'h5555AAAA);
    check("pf_count", 64'(count), 64'd1);
    check("pf_ptr", 64'(wr_ptr), 64'd1);

    reset_n = 1'b0;
    flush   = 1'b1;
    wr(2'b11, 32'h77777777, 32'h88888888);
    reset_n = 1'b1;
    flush   = 1'b0;
    check("mr_count", 64'(count), 64'd0);
    check("mr_valid", 64'(valid), 64'h0);
    check("mr_ptr", 64'(wr_ptr), 64'd0);
    check("mr_slot0", 64'(slot(0)), 64'h0);
    check("mr_slot1", 64'(slot(1)), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
